// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the memory port arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

  // Wide enough for any supported DW; users slice the low DW/8 bits.
  localparam logic [127:0] BE_FULL = '1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - shared memory port bundle between arbiter and memory
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW/8-1:0] mem_be;
  logic            mem_rd;
  logic            mem_wr;
  logic            mem_ready;
  logic [DW-1:0]   mem_rdata;

  modport master (
    output mem_addr, mem_wdata, mem_be, mem_rd, mem_wr,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_be, mem_rd, mem_wr,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/rr2_pick.sv
// rtl/rr2_pick.sv - two-way round-robin selector, ties go to whoever did not own the port last
module rr2_pick
  import mem_arb_pkg::*;
(
  input  logic   req_if,
  input  logic   req_d,
  input  owner_t last_owner,
  output logic   grant_valid,
  output owner_t grant_owner
);

  always_comb begin
    grant_valid = req_if | req_d;
    grant_owner = OWN_IF;
    if (req_if && req_d) begin
      grant_owner = (last_owner == OWN_IF) ? OWN_D : OWN_IF;
    end else if (req_d) begin
      grant_owner = OWN_D;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter and sequencer for the single shared memory port
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            clr_n,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic            if_gnt,
  output logic            if_done,
  output logic [DW-1:0]   if_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  input  logic [DW/8-1:0] d_be,
  output logic            d_gnt,
  output logic            d_done,
  output logic [DW-1:0]   d_rdata,
  mem_port_arbiter_if.master mem,
  output logic            err,
  output logic            busy
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

  state_t          state;
  owner_t          last_owner;
  owner_t          owner;
  logic [CW-1:0]   cnt;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic [DW/8-1:0] be_q;
  logic            we_q;
  logic            rd_q;
  logic            wr_q;
  logic            pick_valid;
  owner_t          pick_owner;

  rr2_pick u_pick (
    .req_if      (if_req),
    .req_d       (d_req),
    .last_owner  (last_owner),
    .grant_valid (pick_valid),
    .grant_owner (pick_owner)
  );

  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign mem.mem_be    = be_q;
  assign mem.mem_rd    = rd_q;
  assign mem.mem_wr    = wr_q;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state      <= IDLE;
      last_owner <= OWN_IF;
      owner      <= OWN_IF;
      cnt        <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      we_q       <= 1'b0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      if_gnt     <= 1'b0;
      d_gnt      <= 1'b0;
      if_done    <= 1'b0;
      d_done     <= 1'b0;
      if_rdata   <= '0;
      d_rdata    <= '0;
      err        <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            owner      <= pick_owner;
            last_owner <= pick_owner;
            cnt        <= '0;
            busy       <= 1'b1;
            state      <= ACCESS;
            if (pick_owner == OWN_D) begin
              addr_q  <= d_addr;
              wdata_q <= d_wdata;
              be_q    <= d_be;
              we_q    <= d_we;
              rd_q    <= ~d_we;
              wr_q    <= d_we;
              d_gnt   <= 1'b1;
            end else begin
              addr_q  <= if_addr;
              wdata_q <= '0;
              be_q    <= BE_FULL[DW/8-1:0];
              we_q    <= 1'b0;
              rd_q    <= 1'b1;
              wr_q    <= 1'b0;
              if_gnt  <= 1'b1;
            end
          end
        end
        ACCESS: begin
          if (mem.mem_ready) begin
            rd_q  <= 1'b0;
            wr_q  <= 1'b0;
            err   <= 1'b0;
            state <= RESP;
            if (owner == OWN_D) begin
              d_done  <= 1'b1;
              d_rdata <= we_q ? '0 : mem.mem_rdata;
            end else begin
              if_done  <= 1'b1;
              if_rdata <= mem.mem_rdata;
            end
          end else if (TIMEOUT != 0 && cnt == CNT_MAX) begin
            // Abort: complete the owner with zero data and flag the error.
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            err      <= 1'b1;
            state    <= RESP;
            if_rdata <= '0;
            d_rdata  <= '0;
            if_done  <= (owner == OWN_IF);
            d_done   <= (owner == OWN_D);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          if_done  <= 1'b0;
          d_done   <= 1'b0;
          if_rdata <= '0;
          d_rdata  <= '0;
          err      <= 1'b0;
          if_gnt   <= 1'b0;
          d_gnt    <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed and randomized self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        clr_n = 1'b0;
  logic        if_req, if_gnt, if_done;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_gnt, d_done;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_be;
  logic        err, busy;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(32), .DW(32)) mif ();

  mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(TO)) dut (
    .clk(clk), .clr_n(clr_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_done(if_done), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata),
    .mem(mif), .err(err), .busy(busy)
  );

  int total = 0;
  int bad = 0;

  // Reference model: one scheduled transaction on a cycle timeline.
  int          free_at, t_start, t_resp, t_waits;
  bit          have, t_to, t_we, t_own, last_d;
  logic [31:0] t_addr, t_wdata, t_rdata;
  logic [3:0]  t_be;
  bit          pend[2];
  int          done_cyc[2];
  logic [31:0] a_addr[2], a_wdata[2];
  logic [3:0]  a_be[2];
  bit          a_we[2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic zero_inputs();
    if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_be = 0;
    mif.mem_ready = 0; mif.mem_rdata = 0;
  endtask

  task automatic do_reset();
    clr_n = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_if_gnt", if_gnt, 0); chk("rst_d_gnt", d_gnt, 0);
    chk("rst_if_done", if_done, 0); chk("rst_d_done", d_done, 0);
    chk("rst_err", err, 0); chk("rst_busy", busy, 0);
    chk("rst_mem_rd", mif.mem_rd, 0); chk("rst_mem_wr", mif.mem_wr, 0);
    chk("rst_mem_addr", mif.mem_addr, 0); chk("rst_if_rdata", if_rdata, 0);
    @(negedge clk);
    clr_n = 1;
  endtask

  task automatic drive(input int c);
    bit own;
    for (int a = 0; a < 2; a++) begin
      if (pend[a] && done_cyc[a] == c - 1) pend[a] = 0;
      if (!pend[a] && $urandom_range(0, 2) == 0) begin
        pend[a] = 1;
        a_addr[a] = $urandom; a_wdata[a] = $urandom; a_be[a] = 4'($urandom);
        a_we[a] = (a == 1) ? 1'($urandom) : 1'b0;
      end
    end
    if_req = pend[0];
    d_req  = pend[1];
    if (c >= free_at) begin
      if_addr = a_addr[0];
      d_addr = a_addr[1]; d_wdata = a_wdata[1]; d_be = a_be[1]; d_we = a_we[1];
      if (pend[0] || pend[1]) begin
        own = (pend[0] && pend[1]) ? !last_d : pend[1];
        last_d = own;
        have = 1; t_own = own; t_start = c;
        t_addr = a_addr[own];
        t_we = own ? a_we[1] : 1'b0;
        t_wdata = a_wdata[own];
        t_be = own ? a_be[1] : 4'hF;
        case ($urandom_range(0, 9))
          6:       t_waits = TO - 1;
          7, 8:    t_waits = TO;
          9:       t_waits = $urandom_range(4, TO - 2);
          default: t_waits = $urandom_range(0, 3);
        endcase
        t_to = (t_waits >= TO);
        t_rdata = 0;
        t_resp = c + 1 + (t_to ? TO : t_waits + 1);
        free_at = t_resp + 1;
        done_cyc[own] = t_resp;
      end
    end else begin
      if_addr = $urandom; d_addr = $urandom; d_wdata = $urandom;
      d_be = 4'($urandom); d_we = 1'($urandom);
    end
    mif.mem_rdata = $urandom;
    if (have && c > t_start && c < t_resp) begin
      mif.mem_ready = !t_to && (c - t_start - 1 == t_waits);
      if (mif.mem_ready) t_rdata = t_we ? 32'h0 : mif.mem_rdata;
    end else begin
      mif.mem_ready = 1'($urandom);
    end
  endtask

  task automatic compare(input int c);
    bit in_acc, in_resp;
    in_acc  = have && c > t_start && c < t_resp;
    in_resp = have && c == t_resp;
    chk("if_gnt", if_gnt, (in_acc || in_resp) && !t_own);
    chk("d_gnt", d_gnt, (in_acc || in_resp) && t_own);
    chk("mem_rd", mif.mem_rd, in_acc && !t_we);
    chk("mem_wr", mif.mem_wr, in_acc && t_we);
    chk("if_done", if_done, in_resp && !t_own);
    chk("d_done", d_done, in_resp && t_own);
    chk("err", err, in_resp && t_to);
    chk("busy", busy, in_acc || in_resp);
    if (in_acc) begin
      chk("mem_addr", mif.mem_addr, t_addr);
      chk("mem_be", mif.mem_be, t_be);
      if (t_we) chk("mem_wdata", mif.mem_wdata, t_wdata);
    end
    if (in_resp && !t_own) chk("if_rdata", if_rdata, t_rdata);
    if (in_resp && t_own) chk("d_rdata", d_rdata, t_rdata);
  endtask

  initial begin
    int cyc;
    zero_inputs();
    do_reset();

    // Single fetch.
    if_req = 1; if_addr = 32'h100;
    step();
    chk("f_mem_rd", mif.mem_rd, 1); chk("f_if_gnt", if_gnt, 1);
    chk("f_addr", mif.mem_addr, 32'h100); chk("f_be", mif.mem_be, 4'hF);
    mif.mem_ready = 1; mif.mem_rdata = 32'h00500093;
    step();
    chk("f_done", if_done, 1); chk("f_rdata", if_rdata, 32'h00500093);
    chk("f_err", err, 0); chk("f_rd_low", mif.mem_rd, 0);
    if_req = 0; mif.mem_ready = 0;
    step();
    chk("f_idle", busy, 0);

    // Store with three wait states; request inputs change during ACCESS.
    d_req = 1; d_we = 1; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF; d_be = 4'b0011;
    step();
    d_addr = 32'hFFFF0000; d_wdata = 32'h12345678; d_be = 4'b1100;
    for (int i = 0; i < 4; i++) begin
      chk("s_mem_wr", mif.mem_wr, 1); chk("s_mem_rd", mif.mem_rd, 0);
      chk("s_addr", mif.mem_addr, 32'h2000); chk("s_wdata", mif.mem_wdata, 32'hDEADBEEF);
      chk("s_be", mif.mem_be, 4'b0011); chk("s_done_early", d_done, 0);
      if (i == 3) mif.mem_ready = 1;
      step();
    end
    chk("s_done", d_done, 1); chk("s_rdata", d_rdata, 0);
    chk("s_err", err, 0); chk("s_wr_low", mif.mem_wr, 0);
    d_req = 0; d_we = 0; mif.mem_ready = 0;
    step();

    // Timeout with mem_ready held low.
    if_req = 1; if_addr = 32'h300; mif.mem_rdata = 32'hAAAA5555;
    step();
    for (int i = 0; i < TO; i++) begin
      chk("t_mem_rd", mif.mem_rd, 1); chk("t_done_early", if_done, 0);
      step();
    end
    chk("t_done", if_done, 1); chk("t_err", err, 1);
    chk("t_rdata", if_rdata, 0); chk("t_rd_low", mif.mem_rd, 0);
    if_req = 0;
    step();
    chk("t_idle", busy, 0); chk("t_err_clr", err, 0);

    // Asynchronous reset in the middle of ACCESS.
    d_req = 1; d_we = 1; d_addr = 32'h40;
    step();
    #2 clr_n = 0;
    #1;
    chk("r_d_gnt", d_gnt, 0); chk("r_mem_wr", mif.mem_wr, 0);
    chk("r_busy", busy, 0); chk("r_addr", mif.mem_addr, 0);
    d_req = 0; d_we = 0; if_req = 1; if_addr = 32'h500;
    @(negedge clk);
    clr_n = 1;
    step();
    chk("r_if_gnt", if_gnt, 1); chk("r_mem_rd", mif.mem_rd, 1);
    chk("r_addr2", mif.mem_addr, 32'h500);
    mif.mem_ready = 1;
    step();
    chk("r_done", if_done, 1);
    if_req = 0; mif.mem_ready = 0;
    step();

    // Simultaneous requests held from reset: D, IF, D, IF.
    zero_inputs();
    do_reset();
    if_req = 1; d_req = 1; mif.mem_ready = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("tie_d_gnt", d_gnt, (i % 2) == 0);
      chk("tie_if_gnt", if_gnt, (i % 2) == 1);
      step();
      chk("tie_overlap", if_gnt & d_gnt, 0);
      step();
      chk("tie_idle", busy, 0);
    end
    zero_inputs();

    // Randomized traffic against the timeline model.
    do_reset();
    free_at = 0; have = 0; last_d = 0;
    pend[0] = 0; pend[1] = 0; done_cyc[0] = -10; done_cyc[1] = -10;
    cyc = 0;
    drive(0);
    repeat (3000) begin
      step();
      cyc++;
      compare(cyc);
      drive(cyc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
